mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 Parameter: STARVE_MAX, default 4, max consecutive data grants while an instruction request waits.
- REQ-002 Parameter: TIMEOUT, default 64, max cycles to wait for ram_ready before abort.
- REQ-003 CLK  in  1  single clock; all state updates on rising edge.
- REQ-004 RST  in  1  reset, synchronous, active-high.
- REQ-005 iREN  in  1  instruction fetch request, held until ihit.
- REQ-006 iaddr  in  32  instruction word address.
- REQ-007 dREN  in  1  data load request, held until dhit.
- REQ-008 dWEN  in  1  data store request, held until dhit.
- REQ-009 daddr  in  32  data address.
- REQ-010 dstore  in  32  store data.
- REQ-011 ram_ready  in  1  RAM completion strobe for the current access.
- REQ-012 ramload  in  32  RAM read data, valid with ram_ready.
- REQ-013 ramREN  out  1  RAM read enable.
- REQ-014 ramWEN  out  1  RAM write enable.
- REQ-015 ramaddr  out  32  RAM address.
- REQ-016 ramstore  out  32  RAM write data.
- REQ-017 ihit  out  1  one-cycle pulse: fetch complete, iload valid.
- REQ-018 iload  out  32  fetched instruction.
- REQ-019 dhit  out  1  one-cycle pulse: load or store complete, dload valid for loads.
- REQ-020 dload  out  32  loaded data.
- REQ-021 err  out  1  one-cycle pulse: RAM timeout abort.

Function
- REQ-022 FSM states: IDLE, IBUSY, DBUSY, IRESP, DRESP.
- REQ-023 IDLE: when dREN|dWEN and the starvation count is below STARVE_MAX, go to DBUSY; else if iREN, go to IBUSY; else stay.
- REQ-024 Starvation: count increments on each data grant made while iREN=1 and clears on each instruction grant; when it equals STARVE_MAX and iREN=1, IDLE grants the instruction side.
- REQ-025 On grant, latch the address, the store data and the operation: dWEN=1 gives write; dREN=1 with dWEN=0 gives read; dREN=dWEN=1 gives write.
- REQ-026 IBUSY/DBUSY: drive ramREN/ramWEN, ramaddr and ramstore from the latched values, constant until exit.
- REQ-027 IBUSY/DBUSY: ram_ready=1 gives a move to IRESP/DRESP, with ramload registered into iload/dload (reads only).
- REQ-028 IBUSY/DBUSY: a wait counter resets on entry and increments each cycle without ram_ready.
  - reaching TIMEOUT gives err=1 for one cycle and a return to IDLE;
  - no hit is issued;
  - the requester retries by keeping its request high.
- REQ-029 IRESP/DRESP: assert ihit/dhit for exactly one cycle, then return to IDLE.
- REQ-030 Hit suppression: if the granted request line is low in the RESP cycle, the hit is suppressed; the RAM access is still completed.
- REQ-031 Latency: request sampled in IDLE at cycle n, ram_ready at cycle n+k (k≥1), hit at cycle n+k+1.
  - Minimum back-to-back period is 3 cycles per access.
- REQ-032 Output ranges and holds:
  - ramREN/ramWEN are zero outside the BUSY states;
  - ihit and dhit are never high in the same cycle;
  - iload/dload hold their last value between hits.
- REQ-033 ram_ready is ignored in IDLE and RESP states.
- REQ-034 Request changes during BUSY do not alter the latched access.

Reset
- REQ-035 RST=1 at a clock edge forces the following, overriding everything including a mid-access BUSY:
  - state IDLE;
  - starvation and wait counters 0;
  - ramREN, ramWEN, ihit, dhit and err = 0;
  - ramaddr, ramstore, iload and dload = 0.
- REQ-036 First grant is possible in the cycle after RST deasserts.

Verification
- REQ-037 Instruction fetch: iREN=1 with iaddr=0x40, ram_ready one cycle after ramREN, ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 for 1 cycle; ihit=1 and iload=0x8C220004 on the next cycle.
- REQ-038 Data priority: iREN=dREN=1 in IDLE with daddr=0x100 -> DBUSY first, then dhit; IBUSY follows; ihit arrives 3 cycles after dhit with zero RAM wait.
- REQ-039 Store: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ram_ready after 3 cycles -> ramWEN held 3 cycles with constant address and data; single dhit; ramREN=0 throughout.
- REQ-040 Starvation: iREN=1 with dREN held continuously and STARVE_MAX=4 -> exactly 4 dhits, then ihit, before the 5th dhit.
- REQ-041 Timeout: dREN=1, ram_ready never asserted, TIMEOUT=64 -> err pulses once 64 cycles after DBUSY entry; no dhit; FSM back in IDLE.
- REQ-042 Reset mid-access: RST=1 during IBUSY -> next cycle all outputs are 0 and the FSM is in IDLE; a late ram_ready is ignored; no ihit.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the CPU ports, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the environment (CPU + RAM).
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        ram_ready;
   logic [31:0] ramload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        ihit;
   logic [31:0] iload;
   logic        dhit;
   logic [31:0] dload;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ramload,
      output ramREN, ramWEN, ramaddr, ramstore, ihit, iload, dhit, dload, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ramload,
      input  ramREN, ramWEN, ramaddr, ramstore, ihit, iload, dhit, dload, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data side has priority, instruction side is protected
// from starvation, and a stalled RAM access is aborted after TIMEOUT cycles.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
   localparam logic [WW-1:0] WaitLast  = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StIBusy, StDBusy, StIResp, StDResp} state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   store_q, store_d;
   logic [31:0]   iload_q, iload_d;
   logic [31:0]   dload_q, dload_d;
   logic          write_q, write_d;
   logic          err_q, err_d;
   logic          dreq;

   assign dreq = bus.dREN | bus.dWEN;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      wait_d   = wait_q;
      addr_d   = addr_q;
      store_d  = store_q;
      iload_d  = iload_q;
      dload_d  = dload_q;
      write_d  = write_q;
      err_d    = 1'b0;
      case (state_q)
         StIdle: begin
            // Data wins unless the instruction side has hit its starvation limit.
            if (dreq && (starve_q < StarveMax || !bus.iREN)) begin
               state_d = StDBusy;
               addr_d  = bus.daddr;
               store_d = bus.dstore;
               write_d = bus.dWEN;
               wait_d  = '0;
               if (bus.iREN) starve_d = starve_q + 1'b1;
            end else if (bus.iREN) begin
               state_d  = StIBusy;
               addr_d   = bus.iaddr;
               store_d  = '0;
               write_d  = 1'b0;
               wait_d   = '0;
               starve_d = '0;
            end
         end
         StIBusy, StDBusy: begin
            if (bus.ram_ready) begin
               if (state_q == StIBusy) begin
                  state_d = StIResp;
                  iload_d = bus.ramload;
               end else begin
                  state_d = StDResp;
                  if (!write_q) dload_d = bus.ramload;
               end
            end else if (wait_q == WaitLast) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StIResp, StDResp: state_d = StIdle;
         default:          state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         starve_q <= '0;
         wait_q   <= '0;
         addr_q   <= '0;
         store_q  <= '0;
         iload_q  <= '0;
         dload_q  <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         wait_q   <= wait_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         iload_q  <= iload_d;
         dload_q  <= dload_d;
         write_q  <= write_d;
         err_q    <= err_d;
      end
   end

   // A hit is only reported if the requester still holds its request.
   assign bus.ramREN   = (state_q == StIBusy) | ((state_q == StDBusy) & ~write_q);
   assign bus.ramWEN   = (state_q == StDBusy) & write_q;
   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;
   assign bus.ihit     = (state_q == StIResp) & bus.iREN;
   assign bus.dhit     = (state_q == StDResp) & dreq;
   assign bus.iload    = iload_q;
   assign bus.dload    = dload_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a RAM model and a
// transaction-level reference memory.
module tb_mem_arbiter;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned TIMEOUT    = 64;

   logic CLK = 1'b0;
   logic RST;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   int ntests = 0;
   int nfail  = 0;

   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int ram_delay   = 0;
   bit ram_rand    = 1'b0;
   bit force_ready = 1'b0;
   bit mon_en      = 1'b0;
   int dh_pend     = 0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "ramREN"},   32'(bus.ramREN), 0);
      chk({p, "ramWEN"},   32'(bus.ramWEN), 0);
      chk({p, "ramaddr"},  bus.ramaddr, 0);
      chk({p, "ramstore"}, bus.ramstore, 0);
      chk({p, "ihit"},     32'(bus.ihit), 0);
      chk({p, "dhit"},     32'(bus.dhit), 0);
      chk({p, "err"},      32'(bus.err), 0);
      chk({p, "iload"},    bus.iload, 0);
      chk({p, "dload"},    bus.dload, 0);
   endtask

   // RAM: completes each access after a fixed or random number of extra cycles.
   int  ram_cnt = 0;
   int  ram_cur = 0;
   bit  ram_act = 1'b0;
   always @(negedge CLK) begin
      bus.ramload = $urandom;
      if (bus.ramREN || bus.ramWEN) begin
         if (!ram_act) begin
            ram_act = 1'b1;
            ram_cnt = 0;
            ram_cur = (ram_delay < 0) ? -1 : (ram_rand ? int'($urandom_range(0, 3)) : ram_delay);
         end
         if (ram_cur >= 0 && ram_cnt == ram_cur) begin
            bus.ram_ready = 1'b1;
            bus.ramload   = ram_rd(bus.ramaddr);
            if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
         end else begin
            bus.ram_ready = force_ready;
         end
         ram_cnt++;
      end else begin
         ram_act       = 1'b0;
         bus.ram_ready = force_ready;
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         ntests++;
         assert (!(bus.ihit && bus.dhit) && !(bus.ramREN && bus.ramWEN)) else begin
            nfail++;
            $error("FAIL overlap: ihit=%b dhit=%b ramREN=%b ramWEN=%b, expected at most one of each",
                   bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN);
         end
      end
   end

   // Random-phase requester: retires hits against the reference memory, issues new requests.
   task automatic handle_hits(input bit allow_new);
      if (bus.dhit) begin
         chk("r_dlat", 32'(bus.ram_ready), 1);
         if (bus.iREN) dh_pend++;
         if (bus.dWEN) ref_mem[bus.daddr] = bus.dstore;
         else chk("r_dload", bus.dload, ref_rd(bus.daddr));
         bus.dREN = 1'b0;
         bus.dWEN = 1'b0;
      end else if (allow_new && !(bus.dREN || bus.dWEN) && $urandom_range(0, 2) == 0) begin
         int r;
         r = int'($urandom_range(0, 2));
         bus.dREN   = (r != 1);
         bus.dWEN   = (r != 0);
         bus.daddr  = 32'h1000 + 4 * $urandom_range(0, 7);
         bus.dstore = $urandom;
      end
      if (bus.ihit) begin
         chk("r_ilat", 32'(bus.ram_ready), 1);
         chk("r_iload", bus.iload, ref_rd(bus.iaddr));
         chk("r_starve", 32'(dh_pend <= int'(STARVE_MAX) + 1), 1);
         bus.iREN = 1'b0;
         dh_pend  = 0;
      end else if (allow_new && !bus.iREN && $urandom_range(0, 3) == 0) begin
         bus.iREN  = 1'b1;
         bus.iaddr = 32'h1000 + 4 * $urandom_range(0, 7);
         dh_pend   = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", ntests);
      $fatal(1, "watchdog");
   end

   initial begin
      int  nd, nh, nren, nerr, errat;
      bit  done;

      RST = 1'b1;
      bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
      bus.daddr = '0; bus.dstore = '0; bus.ram_ready = 1'b0; bus.ramload = '0;
      ram_mem[32'h40]  = 32'h8C220004;
      ram_mem[32'h44]  = 32'h22220044;
      ram_mem[32'h48]  = 32'h33330048;
      ram_mem[32'h100] = 32'h11110100;
      repeat (2) tick();
      chk_zero("rst_");
      mon_en = 1'b1;

      // Instruction fetch, granted in the first cycle after reset.
      RST = 1'b0; bus.iREN = 1'b1; bus.iaddr = 32'h40; ram_delay = 0;
      tick();
      chk("f_ren", 32'(bus.ramREN), 1);
      chk("f_addr", bus.ramaddr, 32'h40);
      chk("f_nohit", 32'(bus.ihit), 0);
      tick();
      chk("f_ihit", 32'(bus.ihit), 1);
      chk("f_iload", bus.iload, 32'h8C220004);
      chk("f_ren0", 32'(bus.ramREN), 0);
      bus.iREN = 1'b0;
      tick();
      chk("f_once", 32'(bus.ihit), 0);
      chk("f_hold", bus.iload, 32'h8C220004);

      // Data has priority; instruction follows 3 cycles after dhit.
      bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100;
      tick();
      chk("p_daddr", bus.ramaddr, 32'h100);
      chk("p_dren", 32'(bus.ramREN), 1);
      tick();
      chk("p_dhit", 32'(bus.dhit), 1);
      chk("p_dload", bus.dload, 32'h11110100);
      bus.dREN = 1'b0;
      tick();
      chk("p_gap", 32'(bus.ihit), 0);
      tick();
      chk("p_iaddr", bus.ramaddr, 32'h44);
      tick();
      chk("p_ihit", 32'(bus.ihit), 1);
      chk("p_iload", bus.iload, 32'h22220044);
      bus.iREN = 1'b0;
      tick();

      // Store with a 3-cycle RAM wait; request changes must not disturb the access.
      ram_delay = 2; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s_wen", 32'(bus.ramWEN), 1);
         chk("s_ren", 32'(bus.ramREN), 0);
         chk("s_addr", bus.ramaddr, 32'h200);
         chk("s_data", bus.ramstore, 32'hDEADBEEF);
         chk("s_nohit", 32'(bus.dhit), 0);
         if (i == 0) begin bus.daddr = 32'h300; bus.dstore = 32'h0; end
      end
      tick();
      chk("s_dhit", 32'(bus.dhit), 1);
      chk("s_wen0", 32'(bus.ramWEN), 0);
      bus.dWEN = 1'b0;
      tick();
      chk("s_once", 32'(bus.dhit), 0);
      chk("s_mem", ram_rd(32'h200), 32'hDEADBEEF);
      chk("s_mem_other", ram_rd(32'h300), init_word(32'h300));

      // Starvation limit: 4 data hits, then the instruction.
      ram_delay = 0; bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dREN = 1'b1; bus.daddr = 32'h104;
      nd = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (bus.dhit) nd++;
         if (bus.ihit) begin
            done = 1'b1;
            chk("st_iload", bus.iload, 32'h33330048);
            bus.iREN = 1'b0;
         end
      end
      chk("st_ihit", 32'(done), 1);
      chk("st_dhits", 32'(nd), 4);
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         tick();
         if (bus.dhit) begin done = 1'b1; bus.dREN = 1'b0; end
      end
      chk("st_5th", 32'(done), 1);
      tick();

      // Hit suppression: request dropped mid-access, access still runs to completion.
      ram_delay = 2; bus.dREN = 1'b1; bus.daddr = 32'h108;
      tick();
      chk("sup_busy", 32'(bus.ramREN), 1);
      bus.dREN = 1'b0;
      nd = 0; nren = 0;
      repeat (5) begin
         tick();
         if (bus.dhit) nd++;
         if (bus.ramREN) nren++;
      end
      chk("sup_nohit", 32'(nd), 0);
      chk("sup_ren", 32'(nren), 2);

      // Timeout: RAM never answers.
      ram_delay = -1; bus.dREN = 1'b1; bus.daddr = 32'h10C;
      tick();
      chk("t_busy", 32'(bus.ramREN), 1);
      nerr = 0; errat = -1; nd = 0;
      for (int c = 1; c <= 70; c++) begin
         tick();
         if (bus.dhit) nd++;
         if (bus.err) begin
            nerr++;
            if (errat < 0) errat = c;
            chk("t_idle", 32'(bus.ramREN), 0);
            bus.dREN = 1'b0;
         end
      end
      chk("t_errcnt", 32'(nerr), 1);
      chk("t_errat", 32'(errat), TIMEOUT);
      chk("t_nohit", 32'(nd), 0);
      chk("t_idle2", 32'(bus.ramREN), 0);

      // Reset in the middle of a fetch; stray ram_ready afterwards is ignored.
      ram_delay = 3; bus.iREN = 1'b1; bus.iaddr = 32'h50;
      tick();
      chk("r_busy", 32'(bus.ramREN), 1);
      RST = 1'b1;
      tick();
      chk_zero("rmid_");
      bus.iREN = 1'b0; RST = 1'b0; force_ready = 1'b1;
      nh = 0; nren = 0;
      repeat (3) begin
         tick();
         if (bus.ihit || bus.dhit) nh++;
         if (bus.ramREN || bus.ramWEN) nren++;
      end
      chk("rmid_nohit", 32'(nh), 0);
      chk("rmid_idle", 32'(nren), 0);
      force_ready = 1'b0;

      // Randomized traffic against the reference memory.
      ram_rand = 1'b1;
      dh_pend = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         handle_hits(1'b1);
      end
      for (int c = 0; c < 300 && (bus.iREN || bus.dREN || bus.dWEN); c++) begin
         tick();
         handle_hits(1'b0);
      end
      chk("r_drain", 32'({bus.iREN, bus.dREN, bus.dWEN}), 0);
      for (int k = 0; k < 8; k++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'(4 * k);
         chk("r_mem", ram_rd(a), ref_rd(a));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
